stream_arbiter: RTL and testbench

// Round-robin arbiter sharing one valid/ready FIFO input port between NUM_REQ producer streams.

---
 rtl/stream_arbiter.sv | 125 ++++++++++++
 tb/tb_stream_arbiter.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/stream_arbiter.sv
// stream_arbiter: round-robin arbiter that shares one valid/ready FIFO input
// port between NUM_REQ producer streams. A grant lasts for up to BURST_MAX
// transfers or until the granted requester drops valid. One idle cycle
// separates bursts, and priority rotates from the last granted index.
module stream_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int BURST_MAX  = 8
) (
  input  logic                          clk_in,
  input  logic                          reset_in,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] reqData_in,
  input  logic [NUM_REQ-1:0]            reqValid_in,
  output logic [NUM_REQ-1:0]            reqReady_out,
  output logic [DATA_WIDTH-1:0]         outputData_out,
  output logic                          outputValid_out,
  input  logic                          outputReady_in,
  output logic [NUM_REQ-1:0]            grant_out,
  output logic [$clog2(NUM_REQ)-1:0]    grantIdx_out
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(BURST_MAX + 1);
  // Count value at which the next accepted transfer completes the burst.
  localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(BURST_MAX - 1);
  localparam logic [NUM_REQ-1:0] ONE_HOT_0 = {{(NUM_REQ-1){1'b0}}, 1'b1};

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] g_q, g_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] pick_s;
  logic             found_s;

  // Round-robin search: first valid requester starting just after the last grant.
  always_comb begin
    pick_s  = g_q;
    found_s = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      int idx;
      idx = (int'(g_q) + k) % NUM_REQ;
      if (!found_s && reqValid_in[idx]) begin
        pick_s  = IDX_W'(idx);
        found_s = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
  end

  // State register: FSM state, grant index and burst count.
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      state_q <= IDLE;
      g_q     <= IDX_W'(NUM_REQ - 1);
      cnt_q   <= {CNT_W{1'b0}};
    end else begin
      state_q <= state_d;
      g_q     <= g_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic: arbitrate in IDLE, count transfers and end bursts in BURST.
  always_comb begin
    state_d = state_q;
    g_d     = g_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (found_s) begin
          state_d = BURST;
          g_d     = pick_s;
          cnt_d   = {CNT_W{1'b0}};
        end else begin
          state_d = IDLE;
        end
      end
      BURST: begin
        if (!reqValid_in[g_q]) begin
          // Granted requester released the port; rotate from g next time.
          state_d = IDLE;
        end else if (outputReady_in) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == BURST_LAST) begin
            state_d = IDLE;
          end else begin
            state_d = BURST;
          end
        end else begin
          // Stalled by the FIFO: hold grant and count.
          state_d = BURST;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output logic: zero-latency pass-through of the granted stream, forced quiet in reset.
  always_comb begin
    reqReady_out    = {NUM_REQ{1'b0}};
    outputData_out  = {DATA_WIDTH{1'b0}};
    outputValid_out = 1'b0;
    grant_out       = {NUM_REQ{1'b0}};
    grantIdx_out    = g_q;
    if (reset_in) begin
      reqReady_out    = {NUM_REQ{1'b0}};
      outputValid_out = 1'b0;
    end else if (state_q == BURST) begin
      outputData_out       = reqData_in[int'(g_q)*DATA_WIDTH +: DATA_WIDTH];
      outputValid_out      = reqValid_in[g_q];
      reqReady_out[g_q]    = outputReady_in;
      grant_out            = ONE_HOT_0 << g_q;
    end else begin
      outputValid_out = 1'b0;
    end
  end

endmodule

// File: tb/tb_stream_arbiter.sv
// Testbench for stream_arbiter: three instances (BURST_MAX 4, 8, 1) share
// randomized stimulus and are compared every cycle against a behavioural
// round-robin model, plus transfer-count checks for the throughput cases.
module tb_stream_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;

  logic          clk;
  logic          rst;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]  req_valid;
  logic          out_ready;

  logic [N-1:0]  rdy   [3];
  logic [DW-1:0] odata [3];
  logic          ovalid[3];
  logic [N-1:0]  gnt   [3];
  logic [1:0]    gidx  [3];

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model state per instance: owner (-1 idle), last grant, transfers in burst.
  int bm  [3] = '{4, 8, 1};
  int own [3];
  int lst [3];
  int sent[3];
  int xfers[3];
  bit known = 1'b0;

  stream_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .BURST_MAX(4)) u_b4 (
    .clk_in(clk), .reset_in(rst), .reqData_in(req_data), .reqValid_in(req_valid),
    .reqReady_out(rdy[0]), .outputData_out(odata[0]), .outputValid_out(ovalid[0]),
    .outputReady_in(out_ready), .grant_out(gnt[0]), .grantIdx_out(gidx[0]));

  stream_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .BURST_MAX(8)) u_b8 (
    .clk_in(clk), .reset_in(rst), .reqData_in(req_data), .reqValid_in(req_valid),
    .reqReady_out(rdy[1]), .outputData_out(odata[1]), .outputValid_out(ovalid[1]),
    .outputReady_in(out_ready), .grant_out(gnt[1]), .grantIdx_out(gidx[1]));

  stream_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .BURST_MAX(1)) u_b1 (
    .clk_in(clk), .reset_in(rst), .reqData_in(req_data), .reqValid_in(req_valid),
    .reqReady_out(rdy[2]), .outputData_out(odata[2]), .outputValid_out(ovalid[2]),
    .outputReady_in(out_ready), .grant_out(gnt[2]), .grantIdx_out(gidx[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Compare every instance's outputs against the model for the current inputs.
  task automatic check_all();
    for (int k = 0; k < 3; k++) begin
      logic [N-1:0]  e_rdy;
      logic [N-1:0]  e_gnt;
      logic [DW-1:0] e_data;
      logic          e_val;
      e_rdy = '0; e_gnt = '0; e_data = '0; e_val = 1'b0;
      if (!rst && own[k] >= 0) begin
        e_data = req_data[own[k]*DW +: DW];
        e_val  = req_valid[own[k]];
        e_rdy[own[k]] = out_ready;
        e_gnt[own[k]] = 1'b1;
      end
      check_val($sformatf("ready[b%0d]", bm[k]), 32'(rdy[k]), 32'(e_rdy));
      check_val($sformatf("valid[b%0d]", bm[k]), 32'(ovalid[k]), 32'(e_val));
      check_val($sformatf("grant[b%0d]", bm[k]), 32'(gnt[k]), 32'(e_gnt));
      if (!rst) begin
        check_val($sformatf("data[b%0d]", bm[k]), 32'(odata[k]), 32'(e_data));
      end
      if (known) begin
        check_val($sformatf("gidx[b%0d]", bm[k]), 32'(gidx[k]), 32'(lst[k]));
      end
      if (ovalid[k] && out_ready) xfers[k]++;
    end
  endtask

  // Advance the model across one rising edge using the inputs now applied.
  task automatic model_step();
    for (int k = 0; k < 3; k++) begin
      if (rst) begin
        own[k] = -1; lst[k] = N - 1; sent[k] = 0;
      end else if (own[k] < 0) begin
        for (int s = 1; s <= N; s++) begin
          int cand;
          cand = (lst[k] + s) % N;
          if (own[k] < 0 && req_valid[cand]) begin
            own[k] = cand; lst[k] = cand; sent[k] = 0;
          end
        end
      end else if (!req_valid[own[k]]) begin
        own[k] = -1;
      end else if (out_ready) begin
        sent[k]++;
        if (sent[k] == bm[k]) own[k] = -1;
      end
    end
    if (rst) known = 1'b1;
  endtask

  // One cycle: check at the falling edge, update model, apply next inputs after the rising edge.
  task automatic cycle();
    @(negedge clk);
    check_all();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_counts();
    for (int k = 0; k < 3; k++) xfers[k] = 0;
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      own[k] = -1; lst[k] = N - 1; sent[k] = 0; xfers[k] = 0;
    end
    rst = 1'b1; req_valid = 4'b1111; out_ready = 1'b1;
    req_data = 32'h0;
    // Reset held two cycles with every requester valid.
    #1;
    cycle();
    cycle();
    rst = 1'b0;
    // All valid, FIFO always ready: 20 cycles, per-requester data tags.
    clear_counts();
    for (int c = 0; c < 20; c++) begin
      req_data = {8'h30 + 8'(c), 8'h20 + 8'(c), 8'h10 + 8'(c), 8'h00 + 8'(c)};
      cycle();
    end
    check_val("xfers20_b4", 32'(xfers[0]), 32'd16);

    // Single requester (req3) only, from a fresh reset.
    rst = 1'b1; req_valid = 4'b1000;
    cycle();
    rst = 1'b0;
    clear_counts();
    for (int c = 0; c < 20; c++) begin
      req_data = {8'hD0 + 8'(c), 24'h0};
      cycle();
    end
    check_val("xfers20_b4_req3", 32'(xfers[0]), 32'd16);
    check_val("xfers20_b8_req3", 32'(xfers[1]), 32'd17);
    check_val("xfers20_b1_req3", 32'(xfers[2]), 32'd10);

    // Release mid-burst: req1 only, drops after two transfers while req2 waits.
    rst = 1'b1; req_valid = 4'b0010;
    cycle();
    rst = 1'b0;
    req_data = {8'h00, 8'hB0, 8'hA1, 8'h00};
    cycle();                       // IDLE picks req1
    cycle();                       // 0xA1
    req_data[15:8] = 8'hA2;
    cycle();                       // 0xA2
    req_valid = 4'b0100;           // req1 releases, req2 waits
    cycle();
    cycle();
    cycle();

    // Randomized traffic with stalls and occasional reset.
    for (int c = 0; c < 3000; c++) begin
      rst       = ($urandom_range(0, 99) == 0);
      req_valid = 4'($urandom_range(0, 15) | (($urandom_range(0, 3) == 0) ? 0 : 15) & 4'($urandom));
      out_ready = ($urandom_range(0, 3) != 0);
      req_data  = $urandom;
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
